// File: rtl/procco_pkg.sv
// Shared opcode and sequencer-state encodings for the CPU control path.
package procco_pkg;

    localparam int OPCODE_W = 8;

    typedef enum logic [OPCODE_W-1:0] {
        NOP = 8'h00,
        LDA = 8'h01,
        STA = 8'h02,
        ADD = 8'h03,
        JMP = 8'h04,
        JZ  = 8'h05,
        HLT = 8'hFF
    } opcode_t;

    typedef enum logic [2:0] {
        F0,
        F1,
        DEC,
        E0,
        E1,
        E2,
        HALT
    } state_t;

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive memory wait cycles; timeout fires on the wait that would reach MAX_WAIT.
module wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (inc) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout = inc && (wait_cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the shared CPU bus: one bus driver per cycle,
// memory wait states via mem_ready, halt on HLT or on memory timeout.
module control_sequencer #(
    parameter int OPCODE_W = procco_pkg::OPCODE_W,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                flag_zero,
    input  logic                mem_ready,
    output logic                PC_write,
    output logic                PC_read,
    output logic                counter_enable,
    output logic                MAR_read,
    output logic                RAM_write,
    output logic                RAM_read,
    output logic                IR_read,
    output logic                IR_write,
    output logic                A_read,
    output logic                A_write,
    output logic                B_read,
    output logic                ALU_write,
    output logic                halted,
    output logic                illegal_op,
    output logic                bus_error
);

    import procco_pkg::*;

    state_t              state_q;
    state_t              state_d;
    logic [OPCODE_W-1:0] op_q;
    logic                armed_q;
    logic                bus_error_q;
    logic                mem_wait;
    logic                timeout;
    logic                op_lda;
    logic                op_sta;
    logic                op_add;

    assign mem_wait = ((state_q == F1) || (state_q == E1)) && !mem_ready;
    assign op_lda   = (op_q == OPCODE_W'(LDA));
    assign op_sta   = (op_q == OPCODE_W'(STA));
    assign op_add   = (op_q == OPCODE_W'(ADD));

    // Any state change (normal exit or timeout to HALT) restarts the wait count.
    wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_d != state_q),
        .inc     (mem_wait),
        .timeout (timeout)
    );

    // armed_q keeps F0 silent for the first cycle after reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= F0;
            op_q        <= '0;
            armed_q     <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            if (state_q == DEC) begin
                op_q <= ir_opcode;
            end
            if (timeout) begin
                bus_error_q <= 1'b1;
            end
        end
    end

    assign bus_error = bus_error_q;

    always_comb begin
        state_d        = state_q;
        PC_write       = 1'b0;
        PC_read        = 1'b0;
        counter_enable = 1'b0;
        MAR_read       = 1'b0;
        RAM_write      = 1'b0;
        RAM_read       = 1'b0;
        IR_read        = 1'b0;
        IR_write       = 1'b0;
        A_read         = 1'b0;
        A_write        = 1'b0;
        B_read         = 1'b0;
        ALU_write      = 1'b0;
        halted         = 1'b0;
        illegal_op     = 1'b0;

        case (state_q)
            F0: begin
                if (run && armed_q) begin
                    PC_write = 1'b1;
                    MAR_read = 1'b1;
                    state_d  = F1;
                end
            end
            F1: begin
                RAM_write = 1'b1;
                if (mem_ready) begin
                    IR_read        = 1'b1;
                    counter_enable = 1'b1;
                    state_d        = DEC;
                end else if (timeout) begin
                    state_d = HALT;
                end
            end
            DEC: begin
                case (ir_opcode)
                    OPCODE_W'(NOP): state_d = F0;
                    OPCODE_W'(LDA),
                    OPCODE_W'(STA),
                    OPCODE_W'(ADD),
                    OPCODE_W'(JMP): state_d = E0;
                    OPCODE_W'(JZ):  state_d = flag_zero ? E0 : F0;
                    OPCODE_W'(HLT): state_d = HALT;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = F0;
                    end
                endcase
            end
            E0: begin
                IR_write = 1'b1;
                if (op_lda || op_sta || op_add) begin
                    MAR_read = 1'b1;
                    state_d  = E1;
                end else begin
                    PC_read = 1'b1;
                    state_d = F0;
                end
            end
            E1: begin
                // STA drives the accumulator onto the bus; LDA/ADD let RAM drive.
                A_write   = op_sta;
                RAM_write = !op_sta;
                if (mem_ready) begin
                    A_read   = op_lda;
                    RAM_read = op_sta;
                    B_read   = op_add;
                    state_d  = op_add ? E2 : F0;
                end else if (timeout) begin
                    state_d = HALT;
                end
            end
            E2: begin
                ALU_write = 1'b1;
                A_read    = 1'b1;
                state_d   = F0;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = F0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed scoreboard bench for control_sequencer: expected control vectors are queued
// as each step is driven and compared on the following falling edge.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b1;
    logic [7:0] ir_opcode = 8'h00;
    logic       flag_zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic PC_write, PC_read, counter_enable, MAR_read, RAM_write, RAM_read;
    logic IR_read, IR_write, A_read, A_write, B_read, ALU_write;
    logic halted, illegal_op, bus_error;

    localparam logic [14:0] PCW  = 15'h4000;
    localparam logic [14:0] PCR  = 15'h2000;
    localparam logic [14:0] CE   = 15'h1000;
    localparam logic [14:0] MAR  = 15'h0800;
    localparam logic [14:0] RAMW = 15'h0400;
    localparam logic [14:0] RAMR = 15'h0200;
    localparam logic [14:0] IRR  = 15'h0100;
    localparam logic [14:0] IRW  = 15'h0080;
    localparam logic [14:0] AR   = 15'h0040;
    localparam logic [14:0] AW   = 15'h0020;
    localparam logic [14:0] BR   = 15'h0010;
    localparam logic [14:0] ALU  = 15'h0008;
    localparam logic [14:0] HLTD = 15'h0004;
    localparam logic [14:0] ILL  = 15'h0002;
    localparam logic [14:0] BERR = 15'h0001;
    localparam logic [14:0] NONE = 15'h0000;

    typedef struct {
        logic [14:0] v;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [14:0] obs;
    logic [4:0]  drivers;

    assign obs = {PC_write, PC_read, counter_enable, MAR_read, RAM_write, RAM_read,
                  IR_read, IR_write, A_read, A_write, B_read, ALU_write,
                  halted, illegal_op, bus_error};
    assign drivers = {PC_write, RAM_write, IR_write, A_write, ALU_write};

    control_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .ir_opcode      (ir_opcode),
        .flag_zero      (flag_zero),
        .mem_ready      (mem_ready),
        .PC_write       (PC_write),
        .PC_read        (PC_read),
        .counter_enable (counter_enable),
        .MAR_read       (MAR_read),
        .RAM_write      (RAM_write),
        .RAM_read       (RAM_read),
        .IR_read        (IR_read),
        .IR_write       (IR_write),
        .A_read         (A_read),
        .A_write        (A_write),
        .B_read         (B_read),
        .ALU_write      (ALU_write),
        .halted         (halted),
        .illegal_op     (illegal_op),
        .bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        assert (obs === e.v) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.v);
        end
        vectors++;
        assert ($countones(drivers) <= 1) else begin
            miscompares++;
            $error("[TB] FAIL %s_one_driver: observed drivers %b expected at most one set", e.tag, drivers);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic r, input logic [7:0] op,
                                 input logic fz, input logic mr, input logic [14:0] ev,
                                 input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        run       = r;
        ir_opcode = op;
        flag_zero = fz;
        mem_ready = mr;
        e.v   = ev;
        e.tag = tag;
        sb.push_back(e);
        checkOutput();
    endtask

    task automatic step(input logic [7:0] op, input logic mr, input logic [14:0] ev, input string tag);
        applyStimulus(1'b0, 1'b1, op, 1'b0, mr, ev, tag);
    endtask

    task automatic fetch(input string tag);
        step(8'h00, 1'b1, PCW | MAR, {tag, "_f0"});
        step(8'h00, 1'b1, RAMW | IRR | CE, {tag, "_f1"});
    endtask

    initial begin
        #1 reset = 1'b1;

        // Reset with run high, then the silent first cycle, then a NOP
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, NONE, "in_reset");
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, NONE, "first_after_reset");
        fetch("nop");
        step(8'h00, 1'b1, NONE, "nop_dec");

        // LDA and STA; ir_opcode is scrambled in E-states so only the latched op counts
        fetch("lda");
        step(8'h01, 1'b1, NONE, "lda_dec");
        step(8'h02, 1'b1, IRW | MAR, "lda_e0");
        step(8'h02, 1'b1, RAMW | AR, "lda_e1");
        fetch("sta");
        step(8'h02, 1'b1, NONE, "sta_dec");
        step(8'h01, 1'b1, IRW | MAR, "sta_e0");
        step(8'h01, 1'b1, AW | RAMR, "sta_e1");

        // ADD with three wait cycles in E1
        fetch("add");
        step(8'h03, 1'b1, NONE, "add_dec");
        step(8'h00, 1'b1, IRW | MAR, "add_e0");
        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, RAMW, "add_e1_wait");
        step(8'h00, 1'b1, RAMW | BR, "add_e1_ready");
        step(8'h00, 1'b1, ALU | AR, "add_e2");

        // JZ not taken, JZ taken, JMP
        fetch("jz0");
        applyStimulus(1'b0, 1'b1, 8'h05, 1'b0, 1'b1, NONE, "jz0_dec");
        fetch("jz1");
        applyStimulus(1'b0, 1'b1, 8'h05, 1'b1, 1'b1, NONE, "jz1_dec");
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, IRW | PCR, "jz1_e0");
        fetch("jmp");
        step(8'h04, 1'b1, NONE, "jmp_dec");
        step(8'h00, 1'b1, IRW | PCR, "jmp_e0");

        // Illegal opcode, then HLT and an asynchronous reset out of HALT
        fetch("ill");
        step(8'h7A, 1'b1, ILL, "ill_dec");
        fetch("hlt");
        step(8'hFF, 1'b1, NONE, "hlt_dec");
        for (int i = 0; i < 20; i++) step(8'h00, 1'b1, HLTD, "halt_hold");
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        vectors++;
        assert (obs === NONE) else begin
            miscompares++;
            $error("[TB] FAIL async_reset_halt: observed %h expected %h", obs, NONE);
        end
        applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, NONE, "in_reset2");
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, NONE, "first_after_reset2");

        // Waits one short of the limit in F1 and E1 must not time out
        step(8'h00, 1'b1, PCW | MAR, "near_f0");
        for (int i = 0; i < 14; i++) step(8'h00, 1'b0, RAMW, "near_f1_wait");
        step(8'h00, 1'b1, RAMW | IRR | CE, "near_f1_ready");
        step(8'h01, 1'b1, NONE, "near_dec");
        step(8'h00, 1'b1, IRW | MAR, "near_e0");
        for (int i = 0; i < 14; i++) step(8'h00, 1'b0, RAMW, "near_e1_wait");
        step(8'h00, 1'b1, RAMW | AR, "near_e1_ready");

        // Fifteen waits in F1 time out into HALT with a sticky bus_error
        step(8'h00, 1'b1, PCW | MAR, "to_f0");
        for (int i = 0; i < 15; i++) step(8'h00, 1'b0, RAMW, "to_f1_wait");
        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, HLTD | BERR, "to_halt");
        step(8'h00, 1'b1, HLTD | BERR, "to_halt_ready");

        // run low holds F0 silent; raising it starts a fetch
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, NONE, "in_reset3");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, NONE, "first_after_reset3");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, NONE, "run_low");
        fetch("run_high");
        step(8'h00, 1'b1, NONE, "run_high_dec");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
